n64_receive_packet: RTL

//  Parametrised successor to the single-byte N64 command receiver. Decodes a

---
 rtl/n64_receive_packet.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/n64_receive_packet.sv
// Joybus console->controller packet receiver: streams bytes, then reports the length and status.
// Latency: 2-cycle input sync, and each byte strobes one cycle after its 8th bit; no backpressure, so the consumer must take every strobe.
module n64_receive_packet #(
   parameter int CLKS_PER_US = 50,
   parameter int MAX_BYTES   = 35,
   parameter int HIGH_TO_US  = 5,
   parameter int DEAD_US     = 5,
   localparam int LEN_W      = $clog2(MAX_BYTES + 1)
) (
   input  logic             sys_clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             n64d,
   output logic             receiving,
   output logic [7:0]       rx_byte,
   output logic             rx_byte_valid,
   output logic             rx_first,
   output logic             rx_done,
   output logic [LEN_W-1:0] rx_len,
   output logic [1:0]       rx_err,
   output logic             line_dead
);

   localparam int B01    = CLKS_PER_US / 2;
   localparam int B12    = 3 * CLKS_PER_US / 2;
   localparam int B23    = 5 * CLKS_PER_US / 2;
   localparam int B34    = 7 * CLKS_PER_US / 2;
   localparam int DEAD_C = DEAD_US * CLKS_PER_US;
   localparam int HTO_C  = HIGH_TO_US * CLKS_PER_US;
   localparam int TMAX_C = (DEAD_C > HTO_C) ? DEAD_C : HTO_C;
   localparam int TW     = $clog2(TMAX_C + 1);
   localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_BYTES);

   typedef enum logic [2:0] {S_IDLE, S_ARMED, S_LOW, S_HIGH, S_FLUSH, S_DEAD} state_t;

   state_t           state;
   logic             sync1, sync2, line_q;
   logic [TW-1:0]    timer;
   logic [6:0]       shreg;
   logic [2:0]       bit_cnt;
   logic             last_bit;
   logic [LEN_W-1:0] byte_cnt;
   logic [1:0]       err_code;

   logic       line, fall, bit_v;
   logic [7:0] next_shift;

   assign line       = sync2;
   assign fall       = line_q & ~line;
   assign bit_v      = (timer <= TW'(B12));
   assign next_shift = {shreg, bit_v};

   function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] t);
      return (&t) ? t : t + TW'(1);
   endfunction

   always_ff @(posedge sys_clk) begin
      if (reset) begin
         state         <= S_IDLE;
         sync1         <= 1'b1;
         sync2         <= 1'b1;
         line_q        <= 1'b1;
         timer         <= '0;
         shreg         <= '0;
         bit_cnt       <= '0;
         last_bit      <= 1'b0;
         byte_cnt      <= '0;
         err_code      <= '0;
         receiving     <= 1'b0;
         rx_byte       <= '0;
         rx_byte_valid <= 1'b0;
         rx_first      <= 1'b0;
         rx_done       <= 1'b0;
         rx_len        <= '0;
         rx_err        <= '0;
         line_dead     <= 1'b0;
      end else begin
         sync1         <= n64d;
         sync2         <= sync1;
         line_q        <= sync2;
         rx_byte_valid <= 1'b0;
         rx_first      <= 1'b0;
         rx_done       <= 1'b0;
         case (state)
            S_IDLE: begin
               if (enable) state <= S_ARMED;
            end
            S_ARMED: begin
               if (!enable) begin
                  state <= S_IDLE;
               end else if (fall) begin
                  state     <= S_LOW;
                  receiving <= 1'b1;
                  timer     <= TW'(1);
                  bit_cnt   <= '0;
                  byte_cnt  <= '0;
                  shreg     <= '0;
                  last_bit  <= 1'b0;
                  err_code  <= '0;
               end
            end
            S_LOW: begin
               if (!enable) begin
                  state     <= S_IDLE;
                  receiving <= 1'b0;
               end else if (!line) begin
                  if (timer >= TW'(DEAD_C - 1)) begin
                     state     <= S_DEAD;
                     line_dead <= 1'b1;
                     receiving <= 1'b0;
                  end
                  timer <= sat_inc(timer);
               end else begin
                  // Rising edge: classify the completed low pulse width.
                  timer <= TW'(1);
                  if (timer <= TW'(B01) || timer > TW'(B34)) begin
                     err_code <= 2'd1;
                     state    <= S_FLUSH;
                  end else if (timer > TW'(B12) && timer <= TW'(B23)) begin
                     if (bit_cnt == '0 && byte_cnt != '0) begin
                        rx_done   <= 1'b1;
                        rx_err    <= 2'd0;
                        rx_len    <= byte_cnt;
                        receiving <= 1'b0;
                        state     <= S_ARMED;
                     end else begin
                        err_code <= 2'd1;
                        state    <= S_FLUSH;
                     end
                  end else begin
                     shreg    <= next_shift[6:0];
                     bit_cnt  <= bit_cnt + 3'd1;
                     last_bit <= bit_v;
                     state    <= S_HIGH;
                     if (bit_cnt == 3'd7) begin
                        if (byte_cnt == MAX_L) begin
                           err_code <= 2'd3;
                           state    <= S_FLUSH;
                        end else begin
                           rx_byte       <= next_shift;
                           rx_byte_valid <= 1'b1;
                           rx_first      <= (byte_cnt == '0);
                           byte_cnt      <= byte_cnt + LEN_W'(1);
                        end
                     end
                  end
               end
            end
            S_HIGH: begin
               if (!enable) begin
                  state     <= S_IDLE;
                  receiving <= 1'b0;
               end else if (!line) begin
                  state <= S_LOW;
                  timer <= TW'(1);
               end else if (timer >= TW'(HTO_C - 1)) begin
                  // Line idle: a lone trailing 1 bit is the console stop bit.
                  rx_done   <= 1'b1;
                  rx_len    <= byte_cnt;
                  rx_err    <= (bit_cnt == 3'd1 && last_bit && byte_cnt != '0) ? 2'd0 : 2'd2;
                  receiving <= 1'b0;
                  state     <= S_ARMED;
               end else begin
                  timer <= sat_inc(timer);
               end
            end
            S_FLUSH: begin
               if (!enable) begin
                  state     <= S_IDLE;
                  receiving <= 1'b0;
               end else if (!line) begin
                  timer <= '0;
               end else if (timer >= TW'(HTO_C - 1)) begin
                  rx_done   <= 1'b1;
                  rx_len    <= byte_cnt;
                  rx_err    <= err_code;
                  receiving <= 1'b0;
                  state     <= S_ARMED;
               end else begin
                  timer <= sat_inc(timer);
               end
            end
            S_DEAD: begin
               if (line) begin
                  line_dead <= 1'b0;
                  state     <= enable ? S_ARMED : S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
